uart_tx_arbiter: RTL and testbench



---
 rtl/soc_io_pkg.sv | 13 +
 rtl/uart_tx_fifo.sv | 70 +++++++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_io_pkg.sv
// Shared IO-subsystem constants and types for the UART transmit path.
package soc_io_pkg;

    localparam int unsigned UART_DW         = 8;
    localparam int unsigned UART_FIFO_DEPTH = 4;

    // Identifies which hart-side write port a byte came from.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO for one hart-side UART write port.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module uart_tx_fifo
    import soc_io_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned DW    = UART_DW,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // Status comes from the registered count only.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART emitter between two hart-side write ports: two per-port FIFOs
// drained round-robin into a registered valid/ready output stage.
module uart_tx_arbiter
    import soc_io_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned DW    = UART_DW,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_full,
    output logic          a_ovf,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_full,
    output logic          b_ovf,
    output logic          uart_valid,
    output logic [DW-1:0] uart_data,
    input  logic          uart_ready,
    output logic          idle
);

    logic [DW-1:0] a_rdata, b_rdata;
    logic [CW-1:0] a_count, b_count;
    logic          a_empty, b_empty;
    logic          a_pop, b_pop;
    logic          load;

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    // out_src only changes on a pop, so it doubles as the round-robin last_src state.
    src_t          out_src_q, out_src_d;
    logic          a_ovf_q, a_ovf_d;
    logic          b_ovf_q, b_ovf_d;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo_a (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (a_valid),
        .wdata_i (a_data),
        .pop_i   (a_pop),
        .rdata_o (a_rdata),
        .count_o (a_count),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo_b (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (b_valid),
        .wdata_i (b_data),
        .pop_i   (b_pop),
        .rdata_o (b_rdata),
        .count_o (b_count),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    assign load = !out_valid_q || (out_valid_q && uart_ready);

    // Round-robin pick and output-register load; A wins ties when B went last.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        a_pop       = 1'b0;
        b_pop       = 1'b0;
        if (load) begin
            if (!a_empty && (b_empty || out_src_q == SRC_B)) begin
                out_valid_d = 1'b1;
                out_data_d  = a_rdata;
                out_src_d   = SRC_A;
                a_pop       = 1'b1;
            end else if (!b_empty) begin
                out_valid_d = 1'b1;
                out_data_d  = b_rdata;
                out_src_d   = SRC_B;
                b_pop       = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Sticky overflow flags: set when a write hits a full FIFO.
    always_comb begin
        a_ovf_d = a_ovf_q | (a_valid & a_full);
        b_ovf_d = b_ovf_q | (b_valid & b_full);
    end

    // Output stage and overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC_B;
            a_ovf_q     <= 1'b0;
            b_ovf_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            a_ovf_q     <= a_ovf_d;
            b_ovf_q     <= b_ovf_d;
        end
    end

    assign uart_valid = out_valid_q;
    assign uart_data  = out_data_q;
    assign a_ovf      = a_ovf_q;
    assign b_ovf      = b_ovf_q;
    assign idle       = !out_valid_q && (a_count == '0) && (b_count == '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (DEPTH=4, DW=8).
module tb_uart_tx_arbiter;

    logic       clk;
    logic       reset;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_full, a_ovf, b_full, b_ovf;
    logic       uart_valid, uart_ready, idle;
    logic [7:0] uart_data;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx_q[$];

    uart_tx_arbiter #(
        .DEPTH (4),
        .DW    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_full     (a_full),
        .a_ovf      (a_ovf),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_full     (b_full),
        .b_ovf      (b_ovf),
        .uart_valid (uart_valid),
        .uart_data  (uart_data),
        .uart_ready (uart_ready),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake that will complete at the next rising edge.
    always @(negedge clk) begin
        if (!reset && uart_valid && uart_ready) rx_q.push_back(uart_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rx_q.delete();
    endtask

    task automatic wait_rx(input int n, input string tag);
        int cyc = 0;
        while (rx_q.size() < n && cyc < 100) begin
            tick();
            cyc++;
        end
        check(tag, rx_q.size(), n);
    endtask

    initial begin
        reset      = 1'b1;
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        a_data     = '0;
        b_data     = '0;
        uart_ready = 1'b0;
        tick();
        tick();

        // Reset values.
        check("rst_uart_valid", uart_valid, 0);
        check("rst_uart_data", uart_data, 0);
        check("rst_a_full", a_full, 0);
        check("rst_b_full", b_full, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_b_ovf", b_ovf, 0);
        check("rst_idle", idle, 1);
        reset = 1'b0;
        tick();
        rx_q.delete();

        // Single byte: 2-cycle latency, then back to idle.
        uart_ready = 1'b1;
        a_valid    = 1'b1;
        a_data     = 8'h48;
        tick();
        a_valid = 1'b0;
        check("single_no_bypass", uart_valid, 0);
        check("single_not_idle", idle, 0);
        tick();
        check("single_valid", uart_valid, 1);
        check("single_data", uart_data, 8'h48);
        tick();
        check("single_done_valid", uart_valid, 0);
        check("single_idle", idle, 1);
        check("single_rx_cnt", rx_q.size(), 1);
        check("single_rx_byte", rx_q[0], 8'h48);

        // Fill and overflow on port a with the emitter stalled.
        rx_q.delete();
        uart_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(i);
            tick();
            if (i == 4) check("fill_not_full_at4", a_full, 0);
        end
        check("fill_full", a_full, 1);
        check("fill_no_ovf", a_ovf, 0);
        check("fill_head_valid", uart_valid, 1);
        check("fill_head_data", uart_data, 8'h01);
        a_data = 8'h06;
        tick();
        a_valid = 1'b0;
        check("ovf_a_set", a_ovf, 1);
        check("ovf_b_clear", b_ovf, 0);
        uart_ready = 1'b1;
        wait_rx(5, "fill_drain_cnt");
        for (int i = 0; i < 5; i++) check($sformatf("fill_rx%0d", i), rx_q[i], 32'(i + 1));
        tick();
        check("fill_idle", idle, 1);
        check("fill_full_fell", a_full, 0);
        check("ovf_a_sticky", a_ovf, 1);
        do_reset();
        check("ovf_a_reset", a_ovf, 0);

        // Fill and overflow on port b.
        uart_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b_valid = 1'b1;
            b_data  = 8'(8'h10 + i);
            tick();
        end
        check("fill_b_full", b_full, 1);
        check("fill_b_no_ovf", b_ovf, 0);
        b_data = 8'h16;
        tick();
        b_valid = 1'b0;
        check("ovf_b_set", b_ovf, 1);
        check("ovf_b_a_clear", a_ovf, 0);
        do_reset();

        // Round-robin with both ports backlogged.
        uart_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_data  = 8'(8'hA0 + i);
            b_data  = 8'(8'hB0 + i);
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        uart_ready = 1'b1;
        wait_rx(6, "rr_cnt");
        check("rr_0", rx_q[0], 8'hA0);
        check("rr_1", rx_q[1], 8'hB0);
        check("rr_2", rx_q[2], 8'hA1);
        check("rr_3", rx_q[3], 8'hB1);
        check("rr_4", rx_q[4], 8'hA2);
        check("rr_5", rx_q[5], 8'hB2);
        tick();
        check("rr_idle", idle, 1);

        // Backpressure: output holds while ready is low, one transfer per ready-high cycle.
        rx_q.delete();
        uart_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'h70 + i);
            tick();
        end
        a_valid = 1'b0;
        check("bp_offer_valid", uart_valid, 1);
        check("bp_offer_data", uart_data, 8'h71);
        uart_ready = 1'b1;
        tick();
        check("bp_r1_cnt", rx_q.size(), 1);
        check("bp_r1_data", uart_data, 8'h72);
        uart_ready = 1'b0;
        tick();
        check("bp_r0a_valid", uart_valid, 1);
        check("bp_r0a_data", uart_data, 8'h72);
        tick();
        check("bp_r0b_data", uart_data, 8'h72);
        check("bp_r0b_cnt", rx_q.size(), 1);
        uart_ready = 1'b1;
        tick();
        check("bp_r1b_cnt", rx_q.size(), 2);
        check("bp_r1b_data", uart_data, 8'h73);
        uart_ready = 1'b0;
        tick();
        check("bp_hold_cnt", rx_q.size(), 2);
        uart_ready = 1'b1;
        wait_rx(3, "bp_drain_cnt");
        check("bp_rx0", rx_q[0], 8'h71);
        check("bp_rx1", rx_q[1], 8'h72);
        check("bp_rx2", rx_q[2], 8'h73);
        tick();

        // Asynchronous reset with bytes queued and a byte on offer.
        rx_q.delete();
        uart_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'hC0 + i);
            tick();
        end
        a_valid = 1'b0;
        check("mid_pre_valid", uart_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_valid", uart_valid, 0);
        check("mid_async_data", uart_data, 0);
        check("mid_async_idle", idle, 1);
        tick();
        reset      = 1'b0;
        uart_ready = 1'b1;
        repeat (6) tick();
        check("mid_no_stale_cnt", rx_q.size(), 0);
        check("mid_post_valid", uart_valid, 0);
        check("mid_post_idle", idle, 1);

        // Simultaneous pushes into an empty system right after reset.
        rx_q.delete();
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h61;
        b_data  = 8'h62;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_rx(2, "sim_cnt");
        check("sim_first", rx_q[0], 8'h61);
        check("sim_second", rx_q[1], 8'h62);
        tick();
        check("sim_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
